// File: rtl/rat_path_checker.sv
// rat_path_checker: replays the rat's move stream on a 16x16 maze, verifying each step
// against the shared maze memory and reporting pass or a fail cause.
module rat_path_checker #(
  parameter int GOAL_X    = 15,
  parameter int GOAL_Y    = 15,
  parameter int MAX_STEPS = 255,
  parameter int CW        = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    move,
  input  logic          move_valid,
  output logic          move_ready,
  input  logic          stream_end,
  output logic          mem_rd,
  output logic [3:0]    mem_x,
  output logic [3:0]    mem_y,
  input  logic          mem_dout,
  output logic [3:0]    cur_x,
  output logic [3:0]    cur_y,
  output logic [CW-1:0] steps,
  output logic          pass,
  output logic          fail,
  output logic [1:0]    fail_code
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_MOVE = 3'd1,
    CHECK     = 3'd2,
    EVAL      = 3'd3,
    PASS      = 3'd4,
    FAIL      = 3'd5
  } state_t;

  state_t        state;
  logic [3:0]    cand_x;
  logic [3:0]    cand_y;
  logic          oob;
  logic [CW-1:0] step_inc;
  logic          goal_hit;

  // Candidate cell for the offered move; edges never wrap.
  always_comb begin
    cand_x = cur_x;
    cand_y = cur_y;
    oob    = 1'b0;
    case (move)
      2'b00: if (cur_x == 4'd0)  oob = 1'b1; else cand_x = cur_x - 4'd1;
      2'b01: if (cur_y == 4'd15) oob = 1'b1; else cand_y = cur_y + 4'd1;
      2'b10: if (cur_y == 4'd0)  oob = 1'b1; else cand_y = cur_y - 4'd1;
      default: if (cur_x == 4'd15) oob = 1'b1; else cand_x = cur_x + 4'd1;
    endcase
  end

  assign step_inc = steps + {{(CW-1){1'b0}}, 1'b1};
  assign goal_hit = (mem_x == 4'(GOAL_X)) && (mem_y == 4'(GOAL_Y));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      move_ready <= 1'b0;
      mem_rd     <= 1'b0;
      mem_x      <= 4'd0;
      mem_y      <= 4'd0;
      cur_x      <= 4'd0;
      cur_y      <= 4'd0;
      steps      <= '0;
      pass       <= 1'b0;
      fail       <= 1'b0;
      fail_code  <= 2'b00;
    end else begin
      case (state)
        IDLE, PASS, FAIL: begin
          if (start) begin
            cur_x      <= 4'd0;
            cur_y      <= 4'd0;
            steps      <= '0;
            pass       <= 1'b0;
            fail       <= 1'b0;
            fail_code  <= 2'b00;
            move_ready <= 1'b1;
            state      <= WAIT_MOVE;
          end
        end
        WAIT_MOVE: begin
          // A valid move wins over a simultaneous stream_end.
          if (move_valid) begin
            move_ready <= 1'b0;
            if (oob) begin
              fail      <= 1'b1;
              fail_code <= 2'b01;
              state     <= FAIL;
            end else begin
              mem_x  <= cand_x;
              mem_y  <= cand_y;
              mem_rd <= 1'b1;
              state  <= CHECK;
            end
          end else if (stream_end) begin
            move_ready <= 1'b0;
            fail       <= 1'b1;
            fail_code  <= 2'b00;
            state      <= FAIL;
          end
        end
        CHECK: begin
          mem_rd <= 1'b0;
          state  <= EVAL;
        end
        EVAL: begin
          if (mem_dout) begin
            fail      <= 1'b1;
            fail_code <= 2'b10;
            state     <= FAIL;
          end else begin
            cur_x <= mem_x;
            cur_y <= mem_y;
            steps <= step_inc;
            // Goal takes precedence over the step limit.
            if (goal_hit) begin
              pass  <= 1'b1;
              state <= PASS;
            end else if (step_inc == CW'(MAX_STEPS)) begin
              fail      <= 1'b1;
              fail_code <= 2'b11;
              state     <= FAIL;
            end else begin
              move_ready <= 1'b1;
              state      <= WAIT_MOVE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rat_path_checker.sv
// Bench for rat_path_checker: directed moves, expected reads/results queued, monitors compare.
module tb_rat_path_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, move_valid, stream_end;
  logic [1:0] move;

  logic       move_ready, mem_rd, mem_dout, pass, fail;
  logic [3:0] mem_x, mem_y, cur_x, cur_y;
  logic [7:0] steps;
  logic [1:0] fail_code;

  logic       s_move_ready, s_mem_rd, s_mem_dout, s_pass, s_fail;
  logic [3:0] s_mem_x, s_mem_y, s_cur_x, s_cur_y;
  logic [7:0] s_steps;
  logic [1:0] s_fail_code;

  rat_path_checker dut (
    .clk(clk), .rst(rst), .start(start), .move(move), .move_valid(move_valid),
    .move_ready(move_ready), .stream_end(stream_end), .mem_rd(mem_rd), .mem_x(mem_x),
    .mem_y(mem_y), .mem_dout(mem_dout), .cur_x(cur_x), .cur_y(cur_y), .steps(steps),
    .pass(pass), .fail(fail), .fail_code(fail_code)
  );

  rat_path_checker #(.MAX_STEPS(4)) dut_s (
    .clk(clk), .rst(rst), .start(start), .move(move), .move_valid(move_valid),
    .move_ready(s_move_ready), .stream_end(stream_end), .mem_rd(s_mem_rd), .mem_x(s_mem_x),
    .mem_y(s_mem_y), .mem_dout(s_mem_dout), .cur_x(s_cur_x), .cur_y(s_cur_y), .steps(s_steps),
    .pass(s_pass), .fail(s_fail), .fail_code(s_fail_code)
  );

  logic maze [16][16];

  always @(posedge clk) begin
    if (rst) begin
      mem_dout   <= 1'b0;
      s_mem_dout <= 1'b0;
    end else begin
      mem_dout   <= mem_rd   ? maze[mem_x][mem_y]     : 1'b0;
      s_mem_dout <= s_mem_rd ? maze[s_mem_x][s_mem_y] : 1'b0;
    end
  end

  typedef struct {
    logic       p;
    logic       f;
    logic [1:0] code;
    logic [7:0] st;
    logic [3:0] cx;
    logic [3:0] cy;
    int         lat;
  } res_t;

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
  } rd_t;

  res_t q_res[$];
  res_t q_s[$];
  rd_t  q_rd[$];
  int errors = 0;
  int checks = 0;
  int cycle = 0;
  int last_acc = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic cmp_res(input string nm, input res_t e, input logic p, input logic f,
                         input logic [1:0] c, input logic [7:0] st, input logic [3:0] x,
                         input logic [3:0] y, input logic mr, input int lat);
    checks++;
    if (p !== e.p || f !== e.f || (e.f && c !== e.code) || st !== e.st ||
        x !== e.cx || y !== e.cy || mr !== 1'b0 || lat != e.lat) begin
      errors++;
      $display("FAIL %s: got pass=%0b fail=%0b code=%0d steps=%0d cur=(%0d,%0d) ready=%0b lat=%0d; expected pass=%0b fail=%0b code=%0d steps=%0d cur=(%0d,%0d) ready=0 lat=%0d",
               nm, p, f, c, st, x, y, mr, lat, e.p, e.f, e.code, e.st, e.cx, e.cy, e.lat);
    end
  endtask

  // Monitor: memory reads and completion events of the main checker.
  initial begin
    logic prev_done;
    rd_t  er;
    res_t ee;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_rd === 1'b1) begin
        checks++;
        if (q_rd.size() == 0) begin
          errors++;
          $display("FAIL mem_read: got read x=%0d y=%0d, expected no read", mem_x, mem_y);
        end else begin
          er = q_rd.pop_front();
          if (mem_x !== er.x || mem_y !== er.y || (cycle - last_acc) != 1) begin
            errors++;
            $display("FAIL mem_read: got x=%0d y=%0d lat=%0d, expected x=%0d y=%0d lat=1",
                     mem_x, mem_y, cycle - last_acc, er.x, er.y);
          end
        end
      end
      if ((pass | fail) === 1'b1 && !prev_done) begin
        if (q_res.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL result: got unexpected pass=%0b fail=%0b code=%0d, expected none",
                   pass, fail, fail_code);
        end else begin
          ee = q_res.pop_front();
          cmp_res("result", ee, pass, fail, fail_code, steps, cur_x, cur_y, move_ready,
                  cycle - last_acc);
        end
      end
      prev_done = ((pass | fail) === 1'b1);
    end
  end

  // Monitor: step-limited checker, only checked when a result is queued for it.
  initial begin
    logic s_prev;
    res_t ee;
    s_prev = 1'b0;
    forever begin
      @(negedge clk);
      if ((s_pass | s_fail) === 1'b1 && !s_prev && q_s.size() != 0) begin
        ee = q_s.pop_front();
        cmp_res("limit_result", ee, s_pass, s_fail, s_fail_code, s_steps, s_cur_x, s_cur_y,
                s_move_ready, cycle - last_acc);
      end
      s_prev = ((s_pass | s_fail) === 1'b1);
    end
  end

  function automatic res_t mk(input logic p, input logic f, input logic [1:0] c,
                              input logic [7:0] st, input logic [3:0] x, input logic [3:0] y,
                              input int lat);
    res_t r;
    r.p = p; r.f = f; r.code = c; r.st = st; r.cx = x; r.cy = y; r.lat = lat;
    return r;
  endfunction

  function automatic rd_t rd(input int x, input int y);
    rd_t r;
    r.x = 4'(x);
    r.y = 4'(y);
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; move_valid = 1'b0; stream_end = 1'b0; move = 2'b00;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offers a move and returns at the negedge before the accepting posedge.
  task automatic send_move(input logic [1:0] m, input logic se);
    @(negedge clk);
    move = m; move_valid = 1'b1; stream_end = se;
    for (int i = 0; i < 20; i++) begin
      if (move_ready === 1'b1) begin
        last_acc = cycle;
        return;
      end
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL move_accept: got move_ready=0 for 20 cycles, expected 1");
  endtask

  task automatic release_inputs();
    @(negedge clk);
    move_valid = 1'b0; stream_end = 1'b0;
  endtask

  task automatic send_end();
    @(negedge clk);
    move_valid = 1'b0; stream_end = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (move_ready === 1'b1) begin
        last_acc = cycle;
        @(negedge clk);
        stream_end = 1'b0;
        return;
      end
      @(negedge clk);
    end
    checks++;
    errors++;
    stream_end = 1'b0;
    $display("FAIL end_accept: got move_ready=0 for 20 cycles, expected 1");
  endtask

  task automatic wait_sb();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #1;
      if (q_res.size() == 0 && q_s.size() == 0 && q_rd.size() == 0) return;
    end
    checks++;
    errors++;
    $display("FAIL scoreboard_timeout: got res=%0d lim=%0d rd=%0d pending, expected 0",
             q_res.size(), q_s.size(), q_rd.size());
    q_res.delete(); q_s.delete(); q_rd.delete();
  endtask

  task automatic check_idle(input string nm);
    checks++;
    if (move_ready !== 1'b0 || mem_rd !== 1'b0 || pass !== 1'b0 || fail !== 1'b0 ||
        cur_x !== 4'd0 || cur_y !== 4'd0 || steps !== 8'd0 || fail_code !== 2'd0) begin
      errors++;
      $display("FAIL %s: got ready=%0b rd=%0b pass=%0b fail=%0b cur=(%0d,%0d) steps=%0d code=%0d, expected all 0",
               nm, move_ready, mem_rd, pass, fail, cur_x, cur_y, steps, fail_code);
    end
  endtask

  task automatic clear_path();
    q_res.push_back(mk(1'b1, 1'b0, 2'd0, 8'd30, 4'd15, 4'd15, 3));
    for (int i = 1; i <= 15; i++) begin
      q_rd.push_back(rd(i, 0));
      send_move(2'b11, 1'b0);
    end
    for (int j = 1; j <= 15; j++) begin
      q_rd.push_back(rd(15, j));
      send_move(2'b01, 1'b0);
    end
    release_inputs();
    wait_sb();
  endtask

  initial begin
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        maze[x][y] = 1'b0;
    rst = 1'b1; start = 1'b0; move_valid = 1'b0; stream_end = 1'b0; move = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_idle("reset_state");

    // Clear path through an open maze, then stays parked in PASS.
    do_start();
    clear_path();
    repeat (3) @(negedge clk);
    checks++;
    if (pass !== 1'b1 || fail !== 1'b0 || move_ready !== 1'b0) begin
      errors++;
      $display("FAIL pass_hold: got pass=%0b fail=%0b ready=%0b, expected 1 0 0", pass, fail, move_ready);
    end

    // Wall directly below the start cell.
    do_reset();
    maze[1][0] = 1'b1;
    do_start();
    q_rd.push_back(rd(1, 0));
    q_res.push_back(mk(1'b0, 1'b1, 2'b10, 8'd0, 4'd0, 4'd0, 3));
    send_move(2'b11, 1'b0);
    release_inputs();
    wait_sb();
    maze[1][0] = 1'b0;

    // Out of bounds at (0,0) going up, then restart from FAIL and exit right at (0,15).
    do_reset();
    do_start();
    q_res.push_back(mk(1'b0, 1'b1, 2'b01, 8'd0, 4'd0, 4'd0, 1));
    send_move(2'b00, 1'b0);
    release_inputs();
    wait_sb();
    do_start();
    for (int j = 1; j <= 15; j++) begin
      q_rd.push_back(rd(0, j));
      send_move(2'b01, 1'b0);
    end
    q_res.push_back(mk(1'b0, 1'b1, 2'b01, 8'd15, 4'd0, 4'd15, 1));
    send_move(2'b01, 1'b0);
    release_inputs();
    wait_sb();

    // Step limit of 4 on the second instance; the main instance keeps waiting.
    do_reset();
    do_start();
    q_s.push_back(mk(1'b0, 1'b1, 2'b11, 8'd4, 4'd0, 4'd0, 3));
    q_rd.push_back(rd(0, 1)); send_move(2'b01, 1'b0);
    q_rd.push_back(rd(0, 0)); send_move(2'b10, 1'b0);
    q_rd.push_back(rd(0, 1)); send_move(2'b01, 1'b0);
    q_rd.push_back(rd(0, 0)); send_move(2'b10, 1'b0);
    release_inputs();
    wait_sb();

    // Early end after three legal moves.
    do_reset();
    do_start();
    q_rd.push_back(rd(1, 0)); send_move(2'b11, 1'b0);
    q_rd.push_back(rd(1, 1)); send_move(2'b01, 1'b0);
    q_rd.push_back(rd(2, 1)); send_move(2'b11, 1'b0);
    q_res.push_back(mk(1'b0, 1'b1, 2'b00, 8'd3, 4'd2, 4'd1, 1));
    send_end();
    wait_sb();

    // Move and stream_end together: the move is still processed.
    do_reset();
    do_start();
    q_rd.push_back(rd(1, 0));
    send_move(2'b11, 1'b1);
    q_res.push_back(mk(1'b0, 1'b1, 2'b00, 8'd1, 4'd1, 4'd0, 1));
    send_end();
    wait_sb();

    // Reset asserted during CHECK, then a full valid path.
    do_reset();
    do_start();
    q_rd.push_back(rd(1, 0));
    send_move(2'b11, 1'b0);
    @(negedge clk);
    rst = 1'b1; move_valid = 1'b0;
    @(negedge clk);
    check_idle("reset_mid_check");
    rst = 1'b0;
    do_start();
    clear_path();

    checks++;
    if (q_res.size() != 0 || q_s.size() != 0 || q_rd.size() != 0) begin
      errors++;
      $display("FAIL final_queues: got res=%0d lim=%0d rd=%0d pending, expected 0",
               q_res.size(), q_s.size(), q_rd.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
